// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressable little-endian data memory with misalignment flagging
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    input  logic                 memwrite,
    input  logic                 memread,
    input  logic [1:0]           size,
    input  logic                 load_unsigned,
    output logic [31:0]          read_data,
    output logic                 misaligned,
    output logic                 error_sticky,
    output logic [CNT_WIDTH-1:0] store_count
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [31:0]          mem_q [DEPTH_WORDS];
    logic [AW-1:0]        word_idx;
    logic [1:0]           lane;
    logic [31:0]          rd_word;
    logic                 store_en;
    logic [3:0]           byte_en;
    logic [31:0]          wr_lanes;
    logic [31:0]          wr_word_d;
    logic [7:0]           byte_val;
    logic [15:0]          half_val;
    logic [CNT_WIDTH-1:0] store_count_q;
    logic                 error_q;

    // Bits above the memory size are deliberately dropped so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[31:AW+2];

    assign word_idx = address[AW+1:2];
    assign lane     = address[1:0];
    assign rd_word  = mem_q[word_idx];

    assign misaligned = (memread | memwrite) &
                        ((size == 2'b11) |
                         ((size == SZ_HALF) & address[0]) |
                         ((size == SZ_WORD) & (address[1:0] != 2'b00)));

    assign store_en = memwrite & ~misaligned;

    // Build lane enables and replicate store data so any lane can pick its byte.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = 32'h0;
        case (size)
            SZ_BYTE: begin
                byte_en  = 4'b0001 << lane;
                wr_lanes = {4{write_data[7:0]}};
            end
            SZ_HALF: begin
                byte_en  = address[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{write_data[15:0]}};
            end
            SZ_WORD: begin
                byte_en  = 4'b1111;
                wr_lanes = write_data;
            end
            default: begin
                byte_en  = 4'b0000;
                wr_lanes = 32'h0;
            end
        endcase
        wr_word_d = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                wr_word_d[8*b +: 8] = wr_lanes[8*b +: 8];
            end
        end
    end

    // Memory array: cleared on reset, merged word written back on a legal store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (store_en) begin
            mem_q[word_idx] <= wr_word_d;
        end
    end

    // Committed-store counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_count_q <= '0;
        end else if (store_en) begin
            store_count_q <= store_count_q + CNT_WIDTH'(1);
        end
    end

    // Sticky error flag, only cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (misaligned) begin
            error_q <= 1'b1;
        end
    end

    // Combinational load path with lane select and sign/zero extension.
    always_comb begin
        read_data = 32'h0;
        case (lane)
            2'd0:    byte_val = rd_word[7:0];
            2'd1:    byte_val = rd_word[15:8];
            2'd2:    byte_val = rd_word[23:16];
            default: byte_val = rd_word[31:24];
        endcase
        half_val = address[1] ? rd_word[31:16] : rd_word[15:0];
        if (memread && !misaligned) begin
            case (size)
                SZ_BYTE: read_data = {{24{byte_val[7] & ~load_unsigned}}, byte_val};
                SZ_HALF: read_data = {{16{half_val[15] & ~load_unsigned}}, half_val};
                SZ_WORD: read_data = rd_word;
                default: read_data = 32'h0;
            endcase
        end
    end

    assign error_sticky = error_q;
    assign store_count  = store_count_q;

endmodule
